// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multi-cycle fetch/decode controller: opcode values,
// state encoding and instruction classes.
package cpu_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    // Encoding is visible on state_dbg, so it is fixed explicitly.
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CLS_RTYPE   = 3'd0,
        CLS_ADDI    = 3'd1,
        CLS_LW      = 3'd2,
        CLS_SW      = 3'd3,
        CLS_BEQ     = 3'd4,
        CLS_J       = 3'd5,
        CLS_ILLEGAL = 3'd6
    } iclass_t;

endpackage

// File: rtl/op_classify.sv
// Combinational opcode-to-instruction-class decoder.
module op_classify
    import cpu_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6
) (
    input  logic [OPCODE_W-1:0] opcode,
    output iclass_t             iclass
);

    always_comb begin
        iclass = CLS_ILLEGAL;
        if (opcode == OPCODE_W'(OP_RTYPE))     iclass = CLS_RTYPE;
        else if (opcode == OPCODE_W'(OP_ADDI)) iclass = CLS_ADDI;
        else if (opcode == OPCODE_W'(OP_LW))   iclass = CLS_LW;
        else if (opcode == OPCODE_W'(OP_SW))   iclass = CLS_SW;
        else if (opcode == OPCODE_W'(OP_BEQ))  iclass = CLS_BEQ;
        else if (opcode == OPCODE_W'(OP_J))    iclass = CLS_J;
    end

endmodule

// File: rtl/fetch_decode_ctrl.sv
// Multi-cycle fetch/decode/execute controller with retired-instruction counter.
// Build option ILLEGAL_OP_TRAP_EN: illegal opcodes lock into TRAP instead of running as NOP.
module fetch_decode_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int CNT_W    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                imem_ack,
    input  logic                dmem_ack,
    input  logic                alu_zero,
    output logic                imem_req,
    output logic                ir_load,
    output logic                pc_inc,
    output logic                pc_load,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic                reg_we,
    output logic                trap,
    output logic [2:0]          state_dbg,
    output logic [CNT_W-1:0]    instr_retired
);

    state_t           state_reg;
    iclass_t          iclass_reg;
    iclass_t          dec_class;
    logic [CNT_W-1:0] cnt_reg;

    op_classify #(.OPCODE_W(OPCODE_W)) u_classify (
        .opcode (opcode),
        .iclass (dec_class)
    );

    // The class is captured in DECODE so later states never depend on the IR staying put.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= ST_FETCH;
            iclass_reg <= CLS_RTYPE;
            cnt_reg    <= '0;
        end else begin
            case (state_reg)
                ST_FETCH: begin
                    if (imem_ack) state_reg <= ST_DECODE;
                end
                ST_DECODE: begin
                    iclass_reg <= dec_class;
`ifdef ILLEGAL_OP_TRAP_EN
                    if (dec_class == CLS_ILLEGAL) state_reg <= ST_TRAP;
                    else                          state_reg <= ST_EXEC;
`else
                    state_reg <= ST_EXEC;
`endif
                end
                ST_EXEC: begin
                    case (iclass_reg)
                        CLS_LW, CLS_SW:      state_reg <= ST_MEM;
                        CLS_RTYPE, CLS_ADDI: state_reg <= ST_WB;
                        default: begin
                            state_reg <= ST_FETCH;
                            cnt_reg   <= cnt_reg + CNT_W'(1);
                        end
                    endcase
                end
                ST_MEM: begin
                    if (dmem_ack) begin
                        if (iclass_reg == CLS_LW) begin
                            state_reg <= ST_WB;
                        end else begin
                            state_reg <= ST_FETCH;
                            cnt_reg   <= cnt_reg + CNT_W'(1);
                        end
                    end
                end
                ST_WB: begin
                    state_reg <= ST_FETCH;
                    cnt_reg   <= cnt_reg + CNT_W'(1);
                end
`ifdef ILLEGAL_OP_TRAP_EN
                ST_TRAP: state_reg <= ST_TRAP;
`endif
                default: state_reg <= ST_FETCH;
            endcase
        end
    end

    // Handshake strobes follow the acks in the same cycle, so outputs are decoded
    // from state plus inputs and forced low while reset is held.
    always_comb begin
        imem_req = 1'b0;
        ir_load  = 1'b0;
        pc_inc   = 1'b0;
        pc_load  = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        reg_we   = 1'b0;
        if (rst_n) begin
            case (state_reg)
                ST_FETCH: begin
                    imem_req = 1'b1;
                    ir_load  = imem_ack;
                    pc_inc   = imem_ack;
                end
                ST_EXEC: begin
                    pc_load = (iclass_reg == CLS_J) ||
                              ((iclass_reg == CLS_BEQ) && alu_zero);
                end
                ST_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = (iclass_reg == CLS_SW);
                end
                ST_WB: begin
                    reg_we = 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef ILLEGAL_OP_TRAP_EN
    assign trap = rst_n && (state_reg == ST_TRAP);
`else
    assign trap = 1'b0;
`endif

    assign state_dbg     = state_reg;
    assign instr_retired = cnt_reg;

endmodule

// File: tb/tb_fetch_decode_ctrl.sv
// Randomized self-checking bench for fetch_decode_ctrl; a second instance with a
// 4-bit counter exercises counter wrap under identical stimulus.
module tb_fetch_decode_ctrl;

    localparam int K_R = 0, K_ADDI = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_J = 5, K_ILL = 6;
`ifdef ILLEGAL_OP_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  opcode = 6'h00;
    logic        imem_ack = 1'b0, dmem_ack = 1'b0, alu_zero = 1'b0;

    logic        imem_req, ir_load, pc_inc, pc_load, dmem_req, dmem_we, reg_we, trap;
    logic [2:0]  state_dbg;
    logic [31:0] instr_retired;
    logic        imem_req4, ir_load4, pc_inc4, pc_load4, dmem_req4, dmem_we4, reg_we4, trap4;
    logic [2:0]  state_dbg4;
    logic [3:0]  instr_retired4;

    fetch_decode_ctrl dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .alu_zero(alu_zero), .imem_req(imem_req), .ir_load(ir_load), .pc_inc(pc_inc),
        .pc_load(pc_load), .dmem_req(dmem_req), .dmem_we(dmem_we), .reg_we(reg_we),
        .trap(trap), .state_dbg(state_dbg), .instr_retired(instr_retired)
    );

    fetch_decode_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .alu_zero(alu_zero), .imem_req(imem_req4), .ir_load(ir_load4), .pc_inc(pc_inc4),
        .pc_load(pc_load4), .dmem_req(dmem_req4), .dmem_we(dmem_we4), .reg_we(reg_we4),
        .trap(trap4), .state_dbg(state_dbg4), .instr_retired(instr_retired4)
    );

    always #5 clk = ~clk;

    wire [7:0] obs  = {imem_req, ir_load, pc_inc, pc_load, dmem_req, dmem_we, reg_we, trap};
    wire [7:0] obs4 = {imem_req4, ir_load4, pc_inc4, pc_load4, dmem_req4, dmem_we4, reg_we4, trap4};

    typedef struct packed {
        logic       ia;
        logic       da;
        logic       az;
        logic [5:0] op;
        logic [7:0] eo;
        logic [2:0] es;
    } cyc_t;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_cnt = 0;
    logic [5:0]  cur_op = 6'h00;

    function automatic int kind(input logic [5:0] op);
        case (op)
            6'h00:   return K_R;
            6'h08:   return K_ADDI;
            6'h23:   return K_LW;
            6'h2B:   return K_SW;
            6'h04:   return K_BEQ;
            6'h02:   return K_J;
            default: return K_ILL;
        endcase
    endfunction

    // Builds the expected cycle-by-cycle trace of one instruction from its class and
    // wait counts, then drives and checks it; cut >= 0 stops early before that cycle.
    task automatic run_instr(input logic [5:0] op, input int iw, input int dw,
                             input logic az, input int cut);
        cyc_t c;
        cyc_t plan[$];
        int   k = kind(op);
        bit   trapped = TRAP_EN && (k == K_ILL);
        bit   is_mem = (k == K_LW) || (k == K_SW);
        bit   has_wb = (k == K_R) || (k == K_ADDI) || (k == K_LW);
        for (int w = 0; w <= iw; w++) begin
            c.ia = (w == iw); c.da = 1'($urandom); c.az = 1'($urandom); c.op = cur_op;
            c.eo = {1'b1, c.ia, c.ia, 5'b0}; c.es = 3'd0;
            plan.push_back(c);
        end
        c.ia = 1'($urandom); c.da = 1'($urandom); c.az = 1'($urandom); c.op = op;
        c.eo = 8'h00; c.es = 3'd1;
        plan.push_back(c);
        if (trapped) begin
            for (int t = 0; t < 4; t++) begin
                c.ia = 1'($urandom); c.da = 1'($urandom); c.az = 1'($urandom);
                c.eo = 8'h01; c.es = 3'd5;
                plan.push_back(c);
            end
        end else begin
            c.ia = 1'($urandom); c.da = 1'($urandom);
            c.az = (k == K_BEQ) ? az : 1'($urandom);
            c.eo = {3'b0, (k == K_J) || ((k == K_BEQ) && c.az), 4'b0}; c.es = 3'd2;
            plan.push_back(c);
            if (is_mem) begin
                for (int w = 0; w <= dw; w++) begin
                    c.ia = 1'($urandom); c.da = (w == dw); c.az = 1'($urandom);
                    c.eo = {4'b0, 1'b1, (k == K_SW), 2'b0}; c.es = 3'd3;
                    plan.push_back(c);
                end
            end
            if (has_wb) begin
                c.ia = 1'($urandom); c.da = 1'($urandom); c.az = 1'($urandom);
                c.eo = 8'b0000_0010; c.es = 3'd4;
                plan.push_back(c);
            end
        end

        for (int i = 0; i < plan.size(); i++) begin
            if (cut >= 0 && i == cut) return;
            imem_ack = plan[i].ia; dmem_ack = plan[i].da; alu_zero = plan[i].az;
            opcode = plan[i].op;
            @(negedge clk);
            n_vec++;
            if ({obs, state_dbg} !== {plan[i].eo, plan[i].es} ||
                {obs4, state_dbg4} !== {plan[i].eo, plan[i].es}) begin
                n_err++;
                $display("FAIL trace op=%h cyc=%0d: got outs=%b st=%0d (cnt4 inst outs=%b st=%0d), expected outs=%b st=%0d",
                         op, i, obs, state_dbg, obs4, state_dbg4, plan[i].eo, plan[i].es);
            end
            @(posedge clk); #1;
        end
        cur_op = op;
        if (!trapped) exp_cnt = exp_cnt + 1;
        imem_ack = 1'b0; dmem_ack = 1'b0;
        @(negedge clk);
        n_vec++;
        if (state_dbg !== (trapped ? 3'd5 : 3'd0) || instr_retired !== exp_cnt ||
            instr_retired4 !== exp_cnt[3:0]) begin
            n_err++;
            $display("FAIL retire op=%h: got st=%0d cnt=%0d cnt4=%0d, expected st=%0d cnt=%0d cnt4=%0d",
                     op, state_dbg, instr_retired, instr_retired4, trapped ? 5 : 0,
                     exp_cnt, exp_cnt[3:0]);
        end
        @(posedge clk); #1;
    endtask

    task automatic apply_reset(input int n);
        rst_n = 1'b0;
        for (int i = 0; i < n; i++) begin
            imem_ack = 1'($urandom); dmem_ack = 1'($urandom); alu_zero = 1'($urandom);
            @(negedge clk);
            n_vec++;
            if (obs !== 8'h00 || obs4 !== 8'h00 ||
                (i > 0 && (state_dbg !== 3'd0 || instr_retired !== 32'd0 || instr_retired4 !== 4'd0))) begin
                n_err++;
                $display("FAIL reset cyc=%0d: got outs=%b st=%0d cnt=%0d cnt4=%0d, expected outs=00000000 (st=0 cnt=0 after first edge)",
                         i, obs, state_dbg, instr_retired, instr_retired4);
            end
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        imem_ack = 1'b0; dmem_ack = 1'b0;
        exp_cnt = 0;
    endtask

    task automatic test_reset();
        apply_reset(3);
        // ack in the very first cycle after release must be taken
        run_instr(6'h00, 0, 0, 1'b0, -1);
    endtask

    task automatic test_rtype();
        run_instr(6'h00, 0, 0, 1'b0, -1);
        run_instr(6'h08, 2, 0, 1'b0, -1);
    endtask

    task automatic test_lw_sw();
        run_instr(6'h23, 0, 3, 1'b0, -1);
        run_instr(6'h23, 1, 0, 1'b0, -1);
        run_instr(6'h2B, 0, 0, 1'b0, -1);
        run_instr(6'h2B, 3, 2, 1'b0, -1);
    endtask

    task automatic test_branch();
        run_instr(6'h04, 0, 0, 1'b1, -1);
        run_instr(6'h04, 1, 0, 1'b0, -1);
        run_instr(6'h02, 0, 0, 1'b0, -1);
    endtask

    task automatic test_illegal();
        run_instr(6'h3F, 0, 0, 1'b0, -1);
        if (TRAP_EN) apply_reset(2);
        run_instr(6'h01, 1, 0, 1'b0, -1);
        if (TRAP_EN) apply_reset(2);
    endtask

    task automatic test_reset_mid_mem();
        // SW: 2 fetch cycles, decode, exec, then 2 unacked MEM cycles before reset
        run_instr(6'h2B, 1, 5, 1'b0, 6);
        rst_n = 1'b0; dmem_ack = 1'b1; imem_ack = 1'b0;
        @(negedge clk);
        n_vec++;
        if (obs !== 8'h00) begin
            n_err++;
            $display("FAIL mid_mem_reset_outs: got outs=%b, expected 00000000", obs);
        end
        @(posedge clk); #1;
        rst_n = 1'b1; dmem_ack = 1'b1;
        @(negedge clk);
        n_vec++;
        if (state_dbg !== 3'd0 || dmem_req !== 1'b0 || imem_req !== 1'b1 || instr_retired !== 32'd0) begin
            n_err++;
            $display("FAIL mid_mem_reset_after: got st=%0d dmem_req=%b imem_req=%b cnt=%0d, expected st=0 dmem_req=0 imem_req=1 cnt=0",
                     state_dbg, dmem_req, imem_req, instr_retired);
        end
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        exp_cnt = 0;
    endtask

    task automatic test_reset_mid_fetch();
        run_instr(6'h08, 0, 0, 1'b0, -1);
        run_instr(6'h23, 4, 0, 1'b0, 2);
        apply_reset(2);
        run_instr(6'h2B, 0, 1, 1'b0, -1);
    endtask

    task automatic test_wrap();
        apply_reset(2);
        for (int i = 0; i < 16; i++) run_instr(6'h02, $urandom_range(0, 1), 0, 1'b0, -1);
        @(negedge clk);
        n_vec++;
        if (instr_retired4 !== 4'd0 || instr_retired !== 32'd16) begin
            n_err++;
            $display("FAIL wrap: got cnt4=%0d cnt=%0d, expected cnt4=0 cnt=16",
                     instr_retired4, instr_retired);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [5:0] pool[6] = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h02};
        logic [5:0] op;
        for (int n = 0; n < 60; n++) begin
            op = pool[$urandom_range(0, 5)];
            if (!TRAP_EN && $urandom_range(0, 7) == 0) begin
                op = 6'($urandom_range(0, 63));
                if (kind(op) != K_ILL) op = 6'h3F;
            end
            run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), -1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_rtype();
        test_lw_sw();
        test_branch();
        test_illegal();
        test_reset_mid_mem();
        test_reset_mid_fetch();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_decode_ctrl.md
FETCH_DECODE_CTRL -- requirements
Module: fetch_decode_ctrl

Interface
REQ-001 The block SHALL have parameter OPCODE_W, default 6, giving the opcode field width taken from IR[31:26].
REQ-002 The block SHALL have parameter CNT_W, default 32, giving the retired-instruction counter width.
REQ-003 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1: reset, synchronous, active-low.
REQ-005 Port opcode, input, OPCODE_W: opcode from the instruction register, valid from the cycle after ir_load.
REQ-006 Port imem_ack, input, 1: instruction memory has imem_rdata valid this cycle.
REQ-007 Port dmem_ack, input, 1: data memory access complete this cycle.
REQ-008 Port alu_zero, input, 1: ALU zero flag, sampled in EXEC.
REQ-009 Port imem_req, output, 1: instruction fetch request.
REQ-010 Port ir_load, output, 1: load enable for the instruction register.
REQ-011 Port pc_inc, output, 1: PC <= PC+4.
REQ-012 Port pc_load, output, 1: PC <= branch/jump target.
REQ-013 Port dmem_req, dmem_we, output, 1 each: data memory request; write when dmem_we=1.
REQ-014 Port reg_we, output, 1: register file write enable.
REQ-015 Port trap, output, 1: illegal-opcode trap flag.
REQ-016 Port state_dbg, output, 3: current state encoding.
REQ-017 Port instr_retired, output, CNT_W: retired-instruction count.

Function
REQ-018 States SHALL be FETCH, DECODE, EXEC, MEM, WB, TRAP; the state register SHALL be the only source of state_dbg.
REQ-019 In FETCH, imem_req=1 every cycle until imem_ack; on the imem_ack cycle ir_load=1 and pc_inc=1 (same cycle), next state DECODE; otherwise stay in FETCH.
REQ-020 DECODE SHALL last exactly 1 cycle, classifying opcode: 0x00 R-type, 0x08 ADDI, 0x23 LW, 0x2B SW, 0x04 BEQ, 0x02 J; all others illegal.
REQ-021 EXEC SHALL last exactly 1 cycle; BEQ with alu_zero=1 and J SHALL assert pc_load=1 in EXEC; BEQ with alu_zero=0 SHALL not.
REQ-022 After EXEC: LW/SW -> MEM; R-type/ADDI -> WB; BEQ/J -> FETCH.
REQ-023 In MEM, dmem_req=1 every cycle until dmem_ack; dmem_we=1 throughout for SW only; on dmem_ack LW -> WB, SW -> FETCH.
REQ-024 WB SHALL last exactly 1 cycle with reg_we=1, then -> FETCH.
REQ-025 Minimum latency with 0-wait ack: BEQ/J 3 cycles, R-type/ADDI 4, SW 4, LW 5.
REQ-026 instr_retired SHALL increment by 1 on every transition into FETCH from EXEC, MEM or WB, and wrap from all-ones to 0.
REQ-027 imem_ack outside FETCH and dmem_ack outside MEM SHALL be ignored.
REQ-028 All outputs except instr_retired and state_dbg SHALL be 0 in any state or condition not listed above.

Reset
REQ-029 When rst_n=0 at a rising clk edge, state SHALL become FETCH and instr_retired 0, regardless of current state, including mid-MEM or mid-FETCH wait.
REQ-030 While rst_n=0, imem_req, ir_load, pc_inc, pc_load, dmem_req, dmem_we, reg_we and trap SHALL all be 0.
REQ-031 A pending memory handshake SHALL be abandoned on reset; an ack in the first cycle after reset release SHALL be honoured only for FETCH.

Configuration
REQ-032 With ILLEGAL_OP_TRAP_EN defined, an illegal opcode SHALL go DECODE -> TRAP; TRAP holds trap=1 and stays until reset; instr_retired does not increment.
REQ-033 Without ILLEGAL_OP_TRAP_EN, an illegal opcode SHALL be executed as a NOP: DECODE -> EXEC -> FETCH with no enables, counted as retired; trap is tied to 0 and TRAP is unreachable.

Structure
REQ-034 Package cpu_ctrl_pkg SHALL hold opcode constants, the state enumeration/encoding and the instruction-class type.
REQ-035 Sub-module op_classify SHALL be purely combinational opcode -> class, instantiated once.

Verification
REQ-036 R-type (0x00), imem_ack on the 1st request cycle -> ir_load/pc_inc in cycle 1, reg_we in cycle 4, back in FETCH in cycle 5, instr_retired=1.
REQ-037 LW (0x23), dmem_ack delayed 3 cycles -> dmem_req high 4 cycles, dmem_we=0, reg_we for 1 cycle afterwards.
REQ-038 BEQ (0x04): alu_zero=1 -> pc_load=1 in EXEC; alu_zero=0 -> pc_load stays 0; both return to FETCH.
REQ-039 Opcode 0x3F -> with ILLEGAL_OP_TRAP_EN, trap=1 stuck and count unchanged; without it, NOP and count +1.
REQ-040 rst_n=0 during SW MEM wait -> next cycle state FETCH, dmem_req=0, instr_retired=0.
REQ-041 With CNT_W=4, run 16 J instructions -> instr_retired wraps 15 -> 0.
